// File: rtl/rvb_wb32.sv
// rvb_wb32: writeback pairing stage behind a Zbb ALU.
// The destination-register tags of accepted instructions are queued in order
// in one FIFO, and the ALU results in a second FIFO. When both queues are
// non-empty, their heads form one writeback pair for the register file.
// Optional feature macro: RVB_WB32_X0_DROP_EN. When it is defined, a pair
// whose tag is x0 is retired silently and is never presented on wb_*.
// Default build (macro undefined): x0 pairs are presented like any other pair.

module rvb_wb32 #(
    parameter int DEPTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       tag_push,
    input  logic [4:0]                 tag_rd,
    output logic                       tag_full,
    input  logic                       alu_valid,
    output logic                       alu_ready,
    input  logic [31:0]                alu_rd,
    output logic                       wb_valid,
    input  logic                       wb_ready,
    output logic [4:0]                 wb_addr,
    output logic [31:0]                wb_data,
    output logic [$clog2(DEPTH):0]     tag_count,
    output logic [$clog2(DEPTH):0]     res_count,
    output logic                       err
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    // Storage arrays are not reset; the counts alone decide which slots are live.
    logic [4:0]    tag_mem_q [DEPTH];
    logic [31:0]   res_mem_q [DEPTH];

    logic [AW-1:0] tag_wp_q, tag_wp_d, tag_rp_q, tag_rp_d;
    logic [AW-1:0] res_wp_q, res_wp_d, res_rp_q, res_rp_d;
    logic [CW-1:0] tag_cnt_q, tag_cnt_d, res_cnt_q, res_cnt_d;
    logic          err_q, err_d;

    logic          tag_have_s, res_have_s, pair_s, x0_s;
    logic          tag_space_s, res_space_s;
    logic          tag_wr_s, res_wr_s, pop_s, wb_valid_s;
    logic [4:0]    tag_head_s;
    logic [31:0]   res_head_s;

    // Handshake decode: space and presence come from the registered counts only.
    always_comb begin
        tag_have_s  = (tag_cnt_q != {CW{1'b0}});
        res_have_s  = (res_cnt_q != {CW{1'b0}});
        pair_s      = tag_have_s && res_have_s;
        tag_space_s = (tag_cnt_q != DEPTH_C);
        res_space_s = (res_cnt_q != DEPTH_C);
        tag_head_s  = tag_mem_q[tag_rp_q];
        res_head_s  = res_mem_q[res_rp_q];
`ifdef RVB_WB32_X0_DROP_EN
        x0_s        = pair_s && (tag_head_s == 5'd0);
`else
        x0_s        = 1'b0;
`endif
        wb_valid_s  = pair_s && !x0_s;
        pop_s       = (wb_valid_s && wb_ready) || x0_s;
        tag_wr_s    = tag_push && tag_space_s;
        res_wr_s    = alu_valid && res_space_s;
    end

    // Next-state pointers, occupancy counters, and sticky error.
    always_comb begin
        tag_wp_d = tag_wr_s ? (tag_wp_q + AW'(1)) : tag_wp_q;
        res_wp_d = res_wr_s ? (res_wp_q + AW'(1)) : res_wp_q;
        tag_rp_d = pop_s    ? (tag_rp_q + AW'(1)) : tag_rp_q;
        res_rp_d = pop_s    ? (res_rp_q + AW'(1)) : res_rp_q;

        case ({tag_wr_s, pop_s})
            2'b10:   tag_cnt_d = tag_cnt_q + CW'(1);
            2'b01:   tag_cnt_d = tag_cnt_q - CW'(1);
            default: tag_cnt_d = tag_cnt_q;
        endcase

        case ({res_wr_s, pop_s})
            2'b10:   res_cnt_d = res_cnt_q + CW'(1);
            2'b01:   res_cnt_d = res_cnt_q - CW'(1);
            default: res_cnt_d = res_cnt_q;
        endcase

        // A dropped tag, or a result that has no tag to pair with, is a protocol error.
        err_d = err_q
              | (tag_push && !tag_space_s)
              | (res_wr_s && !tag_have_s && !tag_push);
    end

    // Pointer, count and error state, cleared asynchronously by reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tag_wp_q  <= {AW{1'b0}};
            tag_rp_q  <= {AW{1'b0}};
            res_wp_q  <= {AW{1'b0}};
            res_rp_q  <= {AW{1'b0}};
            tag_cnt_q <= {CW{1'b0}};
            res_cnt_q <= {CW{1'b0}};
            err_q     <= 1'b0;
        end else begin
            tag_wp_q  <= tag_wp_d;
            tag_rp_q  <= tag_rp_d;
            res_wp_q  <= res_wp_d;
            res_rp_q  <= res_rp_d;
            tag_cnt_q <= tag_cnt_d;
            res_cnt_q <= res_cnt_d;
            err_q     <= err_d;
        end
    end

    // Queue storage writes: the slot at the write pointer captures the new entry.
    always_ff @(posedge clock) begin
        if (tag_wr_s) begin
            tag_mem_q[tag_wp_q] <= tag_rd;
        end
        if (res_wr_s) begin
            res_mem_q[res_wp_q] <= alu_rd;
        end
    end

    // Output map. The heads are gated to zero while no pair exists, so the
    // unreset storage never shows on wb_*.
    always_comb begin
        tag_full  = !tag_space_s;
        alu_ready = res_space_s;
        wb_valid  = wb_valid_s;
        wb_addr   = pair_s ? tag_head_s : 5'd0;
        wb_data   = pair_s ? res_head_s : 32'd0;
        tag_count = tag_cnt_q;
        res_count = res_cnt_q;
        err       = err_q;
    end

endmodule

// File: tb/tb_rvb_wb32.sv
// Bench for rvb_wb32: directed scenarios, then a randomized stream of 10000
// results. The reference model keeps two queues (pending tags and pending
// results) and pairs them in arrival order. A monitor running on the falling
// edge compares every observable output against that model.
`timescale 1ns/1ps
module tb_rvb_wb32;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int N     = 10000;
`ifdef RVB_WB32_X0_DROP_EN
    localparam bit X0DROP = 1'b1;
`else
    localparam bit X0DROP = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          tag_push = 1'b0;
    logic [4:0]    tag_rd = 5'd0;
    logic          tag_full;
    logic          alu_valid = 1'b0;
    logic          alu_ready;
    logic [31:0]   alu_rd = 32'd0;
    logic          wb_valid;
    logic          wb_ready = 1'b0;
    logic [4:0]    wb_addr;
    logic [31:0]   wb_data;
    logic [CW-1:0] tag_count, res_count;
    logic          err;

    rvb_wb32 #(.DEPTH(DEPTH)) dut (
        .clock(clock), .reset(reset),
        .tag_push(tag_push), .tag_rd(tag_rd), .tag_full(tag_full),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd),
        .wb_valid(wb_valid), .wb_ready(wb_ready),
        .wb_addr(wb_addr), .wb_data(wb_data),
        .tag_count(tag_count), .res_count(res_count), .err(err)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state: tags and results that are accepted but not yet retired.
    logic [4:0]  mt [$];
    logic [31:0] mr [$];
    bit          m_err = 1'b0;
    int          pairs = 0;
    int          drops = 0;
    bit          both, drop, ev, tacc, racc;

    // Monitor: checks the outputs on the falling edge, then advances the model
    // by the transfers that the next rising edge will perform.
    always @(negedge clock) begin
        if (!reset) begin
            mt.delete();
            mr.delete();
            m_err = 1'b0;
            chk("rst_wb_valid",  wb_valid,  0);
            chk("rst_tag_full",  tag_full,  0);
            chk("rst_alu_ready", alu_ready, 1);
            chk("rst_tag_count", tag_count, 0);
            chk("rst_res_count", res_count, 0);
            chk("rst_err",       err,       0);
            chk("rst_wb_addr",   wb_addr,   0);
            chk("rst_wb_data",   wb_data,   0);
        end else begin
            both = (mt.size() != 0) && (mr.size() != 0);
            drop = X0DROP && both && (mt[0] == 5'd0);
            ev   = both && !drop;
            chk("tag_count", tag_count, mt.size());
            chk("res_count", res_count, mr.size());
            chk("alu_ready", alu_ready, mr.size() < DEPTH);
            chk("tag_full",  tag_full,  mt.size() == DEPTH);
            chk("err",       err,       m_err);
            chk("wb_valid",  wb_valid,  ev);
            if (ev && wb_ready) begin
                chk("wb_addr", wb_addr, mt[0]);
                chk("wb_data", wb_data, mr[0]);
                pairs++;
            end
            tacc = tag_push && (mt.size() < DEPTH);
            racc = alu_valid && (mr.size() < DEPTH);
            if (tag_push && !tacc) m_err = 1'b1;
            if (racc && (mt.size() == 0) && !tag_push) m_err = 1'b1;
            if ((ev && wb_ready) || drop) begin
                void'(mt.pop_front());
                void'(mr.pop_front());
                if (drop) drops++;
            end
            if (tacc) mt.push_back(tag_rd);
            if (racc) mr.push_back(alu_rd);
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle();
        tag_push  = 1'b0;
        alu_valid = 1'b0;
    endtask

    task automatic push_tag(input logic [4:0] v);
        tag_push = 1'b1;
        tag_rd   = v;
        step();
        tag_push = 1'b0;
    endtask

    // Holds alu_valid until the model shows free space, within a cycle budget.
    task automatic send_res(input logic [31:0] v, input int budget);
        bit acc;
        bit done;
        done      = 1'b0;
        alu_valid = 1'b1;
        alu_rd    = v;
        for (int i = 0; i < budget && !done; i++) begin
            acc = (mr.size() < DEPTH);
            step();
            if (acc) done = 1'b1;
        end
        alu_valid = 1'b0;
        chk("res_accept_in_budget", done, 1);
    endtask

    // Asserts reset between two clock edges and checks the cleared outputs before the next edge.
    task automatic do_reset();
        @(posedge clock);
        #3 reset = 1'b0;
        #1;
        chk("async_tag_count", tag_count, 0);
        chk("async_res_count", res_count, 0);
        chk("async_wb_valid",  wb_valid,  0);
        chk("async_err",       err,       0);
        idle();
        step();
        reset = 1'b1;
    endtask

    int p0, d0, cyc, tags_issued, res_acc;
    bit pending, tacc_d, racc_d;

    initial begin
        idle();
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;

        // Three tags, then three results, with the register file always ready.
        p0 = pairs;
        wb_ready = 1'b1;
        push_tag(5'd5); push_tag(5'd6); push_tag(5'd7);
        send_res(32'h11, 4); send_res(32'h22, 4); send_res(32'h33, 4);
        repeat (2) step();
        chk("r017_pairs", pairs - p0, 3);

        // Back-pressure: the fifth result is held while the result FIFO is full.
        do_reset();
        wb_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_tag(5'(10 + i));
        for (int i = 0; i < 4; i++) send_res(32'h100 + i, 4);
        alu_valid = 1'b1;
        alu_rd    = 32'h55;
        repeat (3) step();
        chk("r018_alu_ready", alu_ready, 0);
        chk("r018_res_count", res_count, 4);
        chk("r018_tag_full",  tag_full,  1);
        p0 = pairs;
        wb_ready = 1'b1;
        send_res(32'h55, 10);
        repeat (6) step();
        chk("r018_drained", pairs - p0, 4);
        push_tag(5'd8);
        repeat (2) step();
        chk("r018_fifth", pairs - p0, 5);
        chk("r018_err", err, 0);

        // A tag pushed into a full tag queue is dropped and sets a sticky error.
        do_reset();
        wb_ready = 1'b0;
        for (int i = 0; i < 4; i++) push_tag(5'(20 + i));
        chk("r019_full", tag_full, 1);
        push_tag(5'd9);
        chk("r019_count", tag_count, 4);
        chk("r019_err", err, 1);
        wb_ready = 1'b1;
        send_res(32'hC0, 4);
        repeat (5) step();
        chk("r019_sticky", err, 1);

        // x0 pair handling.
        do_reset();
        p0 = pairs;
        wb_ready = 1'b1;
        push_tag(5'd0); push_tag(5'd3);
        send_res(32'hAA, 4); send_res(32'hBB, 4);
        repeat (3) step();
        chk("r020_pairs", pairs - p0, X0DROP ? 1 : 2);

        // Asynchronous reset with entries queued, then fresh traffic.
        wb_ready = 1'b0;
        push_tag(5'd1); push_tag(5'd2);
        send_res(32'h10, 4); send_res(32'h20, 4);
        do_reset();
        p0 = pairs;
        wb_ready = 1'b1;
        push_tag(5'd9);
        send_res(32'h99, 4);
        repeat (2) step();
        chk("r021_post_reset", pairs - p0, 1);

        // Randomized stream. A result is offered only while an earlier tag
        // is still unmatched, so no protocol error is expected.
        do_reset();
        p0 = pairs; d0 = drops;
        tags_issued = 0; res_acc = 0; pending = 1'b0; cyc = 0;
        while (res_acc < N && cyc < 80000) begin
            tag_push = ($urandom_range(9) < 6) && (mt.size() < DEPTH) && (tags_issued < N);
            tag_rd   = 5'($urandom);
            if (!pending && (res_acc < tags_issued) && ($urandom_range(9) < 6)) begin
                pending = 1'b1;
                alu_rd  = $urandom;
            end
            alu_valid = pending;
            wb_ready  = ($urandom_range(9) < 6);
            tacc_d = tag_push;
            racc_d = pending && (mr.size() < DEPTH);
            step();
            cyc++;
            if (tacc_d) tags_issued++;
            if (racc_d) begin
                res_acc++;
                pending = 1'b0;
            end
        end
        chk("rand_in_budget", res_acc, N);
        idle();
        wb_ready = 1'b1;
        for (int i = 0; i < 50 && (mt.size() != 0 || mr.size() != 0); i++) step();
        step();
        chk("rand_retired", (pairs - p0) + (drops - d0), N);
        chk("rand_tag_empty", tag_count, 0);
        chk("rand_res_empty", res_count, 0);
        chk("rand_err", err, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
